gray_decoder_monitor: RTL

GRAY_DECODER_MONITOR -- requirements
Module: gray_decoder_monitor

---
 rtl/gray_decoder_monitor.sv | 106 ++++++++++
 1 files changed

// File: rtl/gray_decoder_monitor.sv
// gray_decoder_monitor: synchronizes a Gray count, decodes it to binary and flags +1/-1/illegal steps.
// Define GRAY_DIR_DET_EN to build the inc/dec direction detector; without it inc/dec are tied low.
module gray_decoder_monitor #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] gray_in,
  input  logic         clr_err,
  output logic [N-1:0] bin_out,
  output logic         valid,
  output logic         inc,
  output logic         dec,
  output logic         err,
  output logic         err_sticky,
  output logic [7:0]   err_cnt
);
  typedef enum logic [1:0] {FILL, TRACK, FAULT} state_e;
  localparam logic [N-1:0] ONE = N'(1);
  state_e       state_q;
  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] g_sync, g_prev_q, bin_d, bin_q, diff;
  logic [2:0]   fill_q;
  logic [7:0]   cnt_q;
  logic         live, bad, inc_d, dec_d;
  logic         valid_q, inc_q, dec_q, err_q, sticky_q;
  // Decode the synchronized sample and classify its distance from the previous one.
  always_comb begin
    g_sync = sync_q[SYNC_STAGES-1];
    for (int i = 0; i < N; i++) bin_d[i] = ^(g_sync >> i);
    diff = g_sync ^ g_prev_q;
    bad  = |(diff & (diff - ONE));
    live = state_q != FILL;
  end
`ifdef GRAY_DIR_DET_EN
  logic step;
  // bin_q always holds the decode of g_prev_q, so it serves as the old value.
  always_comb begin
    step  = (diff != '0) && !bad;
    inc_d = step && (bin_d == bin_q + ONE);
    dec_d = step && !inc_d;
  end
`else
  assign inc_d = 1'b0;
  assign dec_d = 1'b0;
`endif
  // Synchronizer chain, previous-sample register and binary output register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      g_prev_q <= '0;
      bin_q    <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      g_prev_q <= g_sync;
      bin_q    <= bin_d;
    end
  end
  // FILL/TRACK/FAULT state machine with registered status, pulses and error count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= FILL;
      fill_q   <= '0;
      valid_q  <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      inc_q <= live && inc_d;
      dec_q <= live && dec_d;
      err_q <= live && bad;
      if (live && bad && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
      case (state_q)
        FILL: begin
          if (fill_q == 3'(SYNC_STAGES)) begin
            state_q <= TRACK;
            valid_q <= 1'b1;
          end else fill_q <= fill_q + 3'd1;
        end
        TRACK: begin
          if (bad) begin
            state_q  <= FAULT;
            sticky_q <= 1'b1;
          end
        end
        default: begin
          if (!bad && clr_err) begin
            state_q  <= TRACK;
            sticky_q <= 1'b0;
          end
        end
      endcase
    end
  end
  assign bin_out    = bin_q;
  assign valid      = valid_q;
  assign inc        = inc_q;
  assign dec        = dec_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;
endmodule
